// File: rtl/booth2_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth2_pp_decoder
// Description : Radix-4 Booth partial-product selector. Produces 0, +-A or
//               +-2A as a 10-bit two's complement value with its MSB
//               inverted (the form consumed by the Wallace-tree datapath).
// Ports       : i_code[2:0]       Booth window {b[2i+1], b[2i], b[2i-1]}
//               i_a[7:0]          multiplicand A
//               i_inversed_a[8:0] -A, 9 bits wide so that -(-128) is exact
//               o_pp_out[9:0]     selected partial product, MSB inverted
// Revision    : 1.0 - initial release
// ============================================================================
module booth2_pp_decoder (
    input  logic [2:0] i_code,
    input  logic [7:0] i_a,
    input  logic [8:0] i_inversed_a,
    output logic [9:0] o_pp_out
);

    logic [9:0] w_pp;

    always_comb begin
        w_pp = 10'd0;
        case (i_code)
            3'b001, 3'b010: w_pp = {{2{i_a[7]}}, i_a};                   // +A
            3'b011:         w_pp = {i_a[7], i_a, 1'b0};                  // +2A
            3'b100:         w_pp = {i_inversed_a, 1'b0};                 // -2A
            3'b101, 3'b110: w_pp = {i_inversed_a[8], i_inversed_a};      // -A
            default:        w_pp = 10'd0;                                // 000 / 111
        endcase
    end

    // Inverted sign bit lets the tree add constants instead of sign-extending.
    assign o_pp_out = {~w_pp[9], w_pp[8:0]};

endmodule

// ============================================================================
// Module      : booth2_seq_mult_ctrl
// Description : Iterative 8x8 signed multiplier. One booth2_pp_decoder is
//               time-shared over four radix-4 steps; the shifted partial
//               products accumulate into a 16-bit product. valid/ready on
//               both the operand and the result side.
// Parameters  : EARLY_TERM  1: stop once the remaining multiplier bits
//                           b[7:2i+1] are all zero
// Ports       : sys_clk     clock, rising edge
//               sys_rst     synchronous active-high reset
//               in_valid    operand pair valid
//               in_ready    operands accepted this cycle (combinational)
//               in_a, in_b  multiplicand / multiplier, two's complement
//               out_valid   product valid, held until out_ready
//               out_ready   consumer accepts product
//               out_p       product A*B, two's complement
//               busy        controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module booth2_seq_mult_ctrl #(
    parameter int EARLY_TERM = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_step;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic        r_out_valid;
    logic [15:0] r_out_p;
    logic        r_busy;

    logic [8:0]  w_b_ext;
    logic [2:0]  w_code;
    logic [8:0]  w_inversed_a;
    logic [9:0]  w_pp_out;
    logic [9:0]  w_pp;
    logic [15:0] w_addend;
    logic [15:0] w_acc_next;
    logic [7:0]  w_b_upper;
    logic        w_last;

    // b[-1] = 0 is appended below the LSB so every window is a plain 3-bit slice.
    assign w_b_ext      = {r_b, 1'b0};
    assign w_code       = w_b_ext[{r_step, 1'b0} +: 3];
    assign w_inversed_a = 9'd0 - {r_a[7], r_a};

    booth2_pp_decoder u_decoder (
        .i_code       (w_code),
        .i_a          (r_a),
        .i_inversed_a (w_inversed_a),
        .o_pp_out     (w_pp_out)
    );

    // Undo the decoder's MSB inversion to get a true signed partial product.
    assign w_pp       = {~w_pp_out[9], w_pp_out[8:0]};
    assign w_addend   = {{6{w_pp[9]}}, w_pp} << {r_step, 1'b0};
    assign w_acc_next = r_acc + w_addend;

    // Multiplier bits above the current window: b[7:2i+1].
    assign w_b_upper  = (r_b >> {r_step, 1'b0}) >> 1;
    assign w_last     = (r_step == 2'd3) || ((EARLY_TERM != 0) && (w_b_upper == 8'd0));

    assign in_ready   = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
    assign out_valid  = r_out_valid;
    assign out_p      = r_out_p;
    assign busy       = r_busy;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= c_st_idle;
            r_step      <= 2'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_acc       <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_p     <= 16'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_acc   <= 16'd0;
                        r_step  <= 2'd0;
                        r_state <= c_st_run;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_run: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                        r_out_p     <= w_acc_next;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: consume and accept on the same edge.
                            r_a     <= in_a;
                            r_b     <= in_b;
                            r_acc   <= 16'd0;
                            r_step  <= 2'd0;
                            r_state <= c_st_run;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth2_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth2_seq_mult_ctrl
// Description : Self-checking bench for booth2_seq_mult_ctrl. Two instances
//               (EARLY_TERM=0 and EARLY_TERM=1) share the input stimulus;
//               a selector picks which instance is observed. Expected
//               products come from a plain signed-multiply model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth2_seq_mult_ctrl;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_a      = 8'd0;
    logic [7:0]  in_b      = 8'd0;

    logic        in_ready0, out_valid0, busy0;
    logic [15:0] out_p0;
    logic        in_ready1, out_valid1, busy1;
    logic [15:0] out_p1;

    bit          sel = 1'b0;
    logic        o_in_ready, o_out_valid, o_busy;
    logic [15:0] o_out_p;

    int checks   = 0;
    int failures = 0;

    assign o_in_ready  = sel ? in_ready1  : in_ready0;
    assign o_out_valid = sel ? out_valid1 : out_valid0;
    assign o_busy      = sel ? busy1      : busy0;
    assign o_out_p     = sel ? out_p1     : out_p0;

    booth2_seq_mult_ctrl #(.EARLY_TERM(0)) u_dut0 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_p     (out_p0),
        .busy      (busy0)
    );

    booth2_seq_mult_ctrl #(.EARLY_TERM(1)) u_dut1 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_p     (out_p1),
        .busy      (busy1)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int pa;
        int pb;
        int pr;
        pa = int'($signed(a));
        pb = int'($signed(b));
        pr = pa * pb;
        return pr[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    // One transaction with out_ready held high: returns cycles from the
    // accept edge to out_valid, and the product seen.
    task automatic op(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic [15:0] p);
        int n;
        n = 0;
        @(posedge sys_clk);
        #1;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!o_in_ready && n < 50) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        lat      = 0;
        while (!o_out_valid && lat < 20) begin
            @(posedge sys_clk);
            #1;
            lat++;
        end
        p = o_out_p;
        @(posedge sys_clk);
        #1;
    endtask

    // Random traffic with random consumer stalls against a scoreboard queue.
    task automatic sweep(input int n);
        logic [15:0] q[$];
        logic [15:0] held_p;
        bit          held;
        bit          acc_now;
        int          sent;
        int          got;
        int          cyc;
        held    = 1'b0;
        held_p  = 16'd0;
        acc_now = 1'b0;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        in_valid = 1'b0;
        while (got < n && cyc < n * 30) begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (acc_now) in_valid = 1'b0;
            if (!in_valid) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                if (sent < n && $urandom_range(3) != 0) in_valid = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            @(negedge sys_clk);
            if (held) begin
                chk("hold_valid", 32'(o_out_valid), 32'd1);
                chk("hold_p", 32'(o_out_p), 32'(held_p));
            end
            if (o_out_valid) begin
                chk("no_spurious_result", 32'(q.size() != 0), 32'd1);
                if (out_ready && q.size() != 0) begin
                    chk("sweep_p", 32'(o_out_p), 32'(q.pop_front()));
                    got++;
                end
            end
            held    = o_out_valid && !out_ready;
            held_p  = o_out_p;
            acc_now = in_valid && o_in_ready;
            if (acc_now) begin
                q.push_back(model(in_a, in_b));
                sent++;
            end
        end
        chk("sweep_count", 32'(got), 32'(n));
        chk("sweep_leftover", 32'(q.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int          lat;
        logic [15:0] p;

        // Reset state
        do_reset();
        chk("rst_in_ready0", 32'(in_ready0), 32'd1);
        chk("rst_out_valid0", 32'(out_valid0), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_out_p0", 32'(out_p0), 32'd0);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);

        // Basic product and fixed latency
        sel = 1'b0;
        op(8'd3, 8'd5, lat, p);
        chk("lat_3x5", 32'(lat), 32'd4);
        chk("p_3x5", 32'(p), 32'd15);
        chk("idle_after_consume", 32'(o_busy), 32'd0);

        // +-2A and -(-128) corners
        op(8'h80, 8'h80, lat, p);
        chk("p_m128xm128", 32'(p), 32'h4000);
        op(8'h80, 8'd127, lat, p);
        chk("p_m128x127", 32'(p), 32'hC080);
        op(8'd127, 8'd127, lat, p);
        chk("p_127x127", 32'(p), 32'd16129);
        op(8'd127, 8'h80, lat, p);
        chk("p_127xm128", 32'(p), 32'(model(8'd127, 8'h80)));

        // Backpressure in DONE, then back-to-back accept
        @(posedge sys_clk);
        #1;
        in_a      = 8'd25;
        in_b      = 8'hFD;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("bp_in_ready_idle", 32'(o_in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'h11;
        in_b     = 8'h22;
        lat      = 0;
        while (!o_out_valid && lat < 20) begin
            @(posedge sys_clk);
            #1;
            lat++;
        end
        chk("bp_lat", 32'(lat), 32'd4);
        repeat (10) begin
            @(posedge sys_clk);
            #1;
            chk("bp_valid_held", 32'(o_out_valid), 32'd1);
            chk("bp_p_held", 32'(o_out_p), 32'hFFB5);
            chk("bp_in_ready_low", 32'(o_in_ready), 32'd0);
        end
        in_a      = 8'h9C;
        in_b      = 8'd50;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(o_in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_valid_drop", 32'(o_out_valid), 32'd0);
        chk("b2b_busy", 32'(o_busy), 32'd1);
        lat = 0;
        while (!o_out_valid && lat < 20) begin
            @(posedge sys_clk);
            #1;
            lat++;
        end
        chk("b2b_lat", 32'(lat), 32'd4);
        chk("b2b_p", 32'(o_out_p), 32'hEC78);
        @(posedge sys_clk);
        #1;
        chk("b2b_consumed", 32'(o_out_valid), 32'd0);

        // Reset during step 2 of RUN
        in_a      = 8'd9;
        in_b      = 8'hF5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_out_valid", 32'(out_valid0), 32'd0);
        chk("abort_out_p", 32'(out_p0), 32'd0);
        chk("abort_in_ready", 32'(in_ready0), 32'd1);
        repeat (8) begin
            @(posedge sys_clk);
            #1;
            chk("abort_no_result", 32'(out_valid0), 32'd0);
        end
        op(8'd9, 8'hF5, lat, p);
        chk("after_abort_p", 32'(p), 32'(model(8'd9, 8'hF5)));
        chk("after_abort_lat", 32'(lat), 32'd4);

        // Early termination instance
        do_reset();
        sel = 1'b1;
        op(8'hF9, 8'd1, lat, p);
        chk("et_lat_b1", 32'(lat), 32'd1);
        chk("et_p_b1", 32'(p), 32'hFFF9);
        op(8'hF9, 8'h40, lat, p);
        chk("et_lat_b40", 32'(lat), 32'd4);
        chk("et_p_b40", 32'(p), 32'hFE40);
        op(8'd77, 8'd0, lat, p);
        chk("et_lat_b0", 32'(lat), 32'd1);
        chk("et_p_b0", 32'(p), 32'd0);
        op(8'd77, 8'd4, lat, p);
        chk("et_lat_b4", 32'(lat), 32'd2);
        chk("et_p_b4", 32'(p), 32'(model(8'd77, 8'd4)));
        op(8'h80, 8'hFF, lat, p);
        chk("et_lat_bm1", 32'(lat), 32'd4);
        chk("et_p_bm1", 32'(p), 32'h0080);

        // Randomized traffic on both instances
        do_reset();
        sel = 1'b0;
        sweep(3000);
        do_reset();
        sel = 1'b1;
        sweep(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
